// File: rtl/secuenciador_operaciones_pkg.sv
// Shared constants and state encoding for the operation sequencer and its bus interface.
package secuenciador_operaciones_pkg;

    localparam int SEL_W       = 2;
    localparam int OPERANDO_W  = 4;
    localparam int RESULTADO_W = 8;
    localparam int NUM_OPS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CARGA   = 3'd1,
        ESPERA  = 3'd2,
        CAPTURA = 3'd3,
        MOSTRAR = 3'd4,
        FIN     = 3'd5
    } estado_t;

endpackage

// File: rtl/secuenciador_operaciones_if.sv
// Bus between the switches/buttons, the sequencer and the funcionMatematica/BCD datapath.
interface secuenciador_operaciones_if;
    import secuenciador_operaciones_pkg::*;

    logic                   tick;
    logic [OPERANDO_W-1:0]  numBinario;
    logic [SEL_W-1:0]       selManual;
    logic                   modoAuto;
    logic                   iniciar;
    logic [RESULTADO_W-1:0] resultado;
    logic [SEL_W-1:0]       selectorOperacion;
    logic [OPERANDO_W-1:0]  numRetenido;
    logic [RESULTADO_W-1:0] resultadoRetenido;
    logic                   valido;
    logic                   ocupado;
    logic                   fin;

    modport master (
        output tick, numBinario, selManual, modoAuto, iniciar, resultado,
        input  selectorOperacion, numRetenido, resultadoRetenido, valido, ocupado, fin
    );

    modport slave (
        input  tick, numBinario, selManual, modoAuto, iniciar, resultado,
        output selectorOperacion, numRetenido, resultadoRetenido, valido, ocupado, fin
    );

endinterface

// File: rtl/secuenciador_operaciones.sv
// Walks the selector through all operations on a start request, capturing and holding each
// result for DWELL_TICKS ticks; with modoAuto low it registers the switches straight through.
module secuenciador_operaciones
    import secuenciador_operaciones_pkg::*;
#(
    parameter int DWELL_TICKS = 4,
    parameter int NUM_OPS     = NUM_OPS_DEF
) (
    input  logic                      clkNexys2,
    input  logic                      Reset,
    secuenciador_operaciones_if.slave bus
);

    localparam int                    CNT_W    = $clog2(DWELL_TICKS) + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DWELL_TICKS - 1);
    localparam logic [SEL_W-1:0]      SEL_LAST = SEL_W'(NUM_OPS - 1);

    estado_t                estado_q, estado_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [OPERANDO_W-1:0]  num_q, num_d;
    logic [RESULTADO_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   valido_q, valido_d;
    logic                   ocupado_q, ocupado_d;
    logic                   fin_q, fin_d;
    logic                   abortar;
    logic                   ultimo_tick;

    // Leaving automatic mode outside IDLE cancels the run without a fin pulse.
    assign abortar     = (estado_q != IDLE) && !bus.modoAuto;
    assign ultimo_tick = bus.tick && (cnt_q == CNT_LAST);

    always_ff @(posedge clkNexys2) begin
        if (Reset) begin
            estado_q  <= IDLE;
            sel_q     <= '0;
            num_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            sel_q     <= sel_d;
            num_q     <= num_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            valido_q  <= valido_d;
            ocupado_q <= ocupado_d;
            fin_q     <= fin_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:    if (bus.modoAuto && bus.iniciar) estado_d = CARGA;
            CARGA:   estado_d = ESPERA;
            ESPERA:  estado_d = CAPTURA;
            CAPTURA: estado_d = MOSTRAR;
            MOSTRAR: if (ultimo_tick) estado_d = (sel_q == SEL_LAST) ? FIN : ESPERA;
            FIN:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
        if (abortar) estado_d = IDLE;
    end

    always_comb begin
        sel_d     = sel_q;
        num_d     = num_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        valido_d  = 1'b0;
        fin_d     = 1'b0;
        ocupado_d = ocupado_q;
        if (abortar) begin
            ocupado_d = 1'b0;
        end else begin
            case (estado_q)
                IDLE: begin
                    // Manual mode: result trails the selector/operand by one cycle.
                    if (!bus.modoAuto) begin
                        sel_d     = bus.selManual;
                        num_d     = bus.numBinario;
                        res_d     = bus.resultado;
                        ocupado_d = 1'b0;
                    end
                end
                CARGA: begin
                    num_d     = bus.numBinario;
                    sel_d     = '0;
                    ocupado_d = 1'b1;
                end
                CAPTURA: begin
                    res_d    = bus.resultado;
                    valido_d = 1'b1;
                    cnt_d    = '0;
                end
                MOSTRAR: begin
                    if (bus.tick) begin
                        if (cnt_q == CNT_LAST) begin
                            if (sel_q != SEL_LAST) sel_d = sel_q + SEL_W'(1);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                FIN: begin
                    fin_d     = 1'b1;
                    ocupado_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.selectorOperacion = sel_q;
    assign bus.numRetenido       = num_q;
    assign bus.resultadoRetenido = res_q;
    assign bus.valido            = valido_q;
    assign bus.ocupado           = ocupado_q;
    assign bus.fin               = fin_q;

endmodule

// File: tb/tb_secuenciador_operaciones.sv
// Two sequencers (dwell 2 with periodic/random ticks, dwell 1 with tick held high) share the
// switch stimulus and are checked every cycle against a timeline model of the sequence.
module tb_secuenciador_operaciones;

    localparam int NOPS = 4;
    localparam int DW_A = 2;
    localparam int DW_B = 1;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst, auto, ini, tick_a, tick_rand;
    logic [1:0] selm;
    logic [3:0] numb;

    secuenciador_operaciones_if if_a ();
    secuenciador_operaciones_if if_b ();

    assign if_a.tick       = tick_a;
    assign if_a.numBinario = numb;
    assign if_a.selManual  = selm;
    assign if_a.modoAuto   = auto;
    assign if_a.iniciar    = ini;
    assign if_a.resultado  = {if_a.numRetenido, 2'b00, if_a.selectorOperacion};

    assign if_b.tick       = 1'b1;
    assign if_b.numBinario = numb;
    assign if_b.selManual  = selm;
    assign if_b.modoAuto   = auto;
    assign if_b.iniciar    = ini;
    assign if_b.resultado  = {if_b.numRetenido, 2'b00, if_b.selectorOperacion};

    secuenciador_operaciones #(.DWELL_TICKS(DW_A), .NUM_OPS(NOPS)) u_dut_a (
        .clkNexys2 (clk),
        .Reset     (rst),
        .bus       (if_a.slave)
    );

    secuenciador_operaciones #(.DWELL_TICKS(DW_B), .NUM_OPS(NOPS)) u_dut_b (
        .clkNexys2 (clk),
        .Reset     (rst),
        .bus       (if_b.slave)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Timeline model: a run started at edge k latches at k+1, captures at k+3, and each
    // later capture lands 2 edges after the dwell-completing tick; fin 1 edge after the last.
    int         n_edge = 0;
    int         cyc = 0;
    logic       m_act [2];
    logic       m_dwell [2];
    int         m_latch_at [2];
    int         m_cap_at [2];
    int         m_fin_at [2];
    int         m_ticks [2];
    int         m_op [2];
    logic [1:0] m_sel [2];
    logic [3:0] m_num [2];
    logic [7:0] m_res [2];
    logic       m_val [2];
    logic       m_fin [2];
    logic       m_ocu [2];

    logic [7:0] cap_val_a [$];
    int         cap_edge_a [$];
    int         cap_edge_b [$];
    int         fin_a = 0;
    int         fin_edge_b = -1;

    function automatic int dwell_of(input int i);
        return (i == 0) ? DW_A : DW_B;
    endfunction

    task automatic model_advance(input int i, input logic tk);
        logic [7:0] stub;
        stub = {m_num[i], 2'b00, m_sel[i]};
        m_val[i] = 1'b0;
        m_fin[i] = 1'b0;
        if (rst) begin
            m_act[i] = 1'b0; m_dwell[i] = 1'b0;
            m_sel[i] = '0; m_num[i] = '0; m_res[i] = '0; m_ocu[i] = 1'b0;
            m_cap_at[i] = -10; m_latch_at[i] = -10; m_fin_at[i] = -10;
        end else if (!m_act[i]) begin
            if (!auto) begin
                m_sel[i] = selm; m_num[i] = numb; m_res[i] = stub; m_ocu[i] = 1'b0;
            end else if (ini) begin
                m_act[i] = 1'b1; m_dwell[i] = 1'b0;
                m_latch_at[i] = n_edge + 1; m_cap_at[i] = n_edge + 3; m_fin_at[i] = -10;
            end
        end else if (!auto) begin
            m_act[i] = 1'b0; m_dwell[i] = 1'b0; m_ocu[i] = 1'b0;
        end else begin
            if (n_edge == m_latch_at[i]) begin
                m_num[i] = numb; m_sel[i] = '0; m_ocu[i] = 1'b1; m_op[i] = 0;
            end
            if (n_edge == m_cap_at[i]) begin
                m_res[i] = stub; m_val[i] = 1'b1; m_ticks[i] = 0; m_dwell[i] = 1'b1;
            end else if (m_dwell[i] && tk) begin
                m_ticks[i]++;
                if (m_ticks[i] == dwell_of(i)) begin
                    m_dwell[i] = 1'b0;
                    if (m_op[i] == NOPS - 1) begin
                        m_fin_at[i] = n_edge + 1;
                    end else begin
                        m_op[i]++;
                        m_sel[i] = m_op[i][1:0];
                        m_cap_at[i] = n_edge + 2;
                    end
                end
            end
            if (n_edge == m_fin_at[i]) begin
                m_fin[i] = 1'b1; m_ocu[i] = 1'b0; m_act[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_edge++;
        model_advance(0, tick_a);
        model_advance(1, 1'b1);
        chk("a.sel",     32'(if_a.selectorOperacion), 32'(m_sel[0]));
        chk("a.num",     32'(if_a.numRetenido),       32'(m_num[0]));
        chk("a.res",     32'(if_a.resultadoRetenido), 32'(m_res[0]));
        chk("a.valido",  32'(if_a.valido),            32'(m_val[0]));
        chk("a.ocupado", 32'(if_a.ocupado),           32'(m_ocu[0]));
        chk("a.fin",     32'(if_a.fin),               32'(m_fin[0]));
        chk("b.sel",     32'(if_b.selectorOperacion), 32'(m_sel[1]));
        chk("b.num",     32'(if_b.numRetenido),       32'(m_num[1]));
        chk("b.res",     32'(if_b.resultadoRetenido), 32'(m_res[1]));
        chk("b.valido",  32'(if_b.valido),            32'(m_val[1]));
        chk("b.ocupado", 32'(if_b.ocupado),           32'(m_ocu[1]));
        chk("b.fin",     32'(if_b.fin),               32'(m_fin[1]));
        if (if_a.valido) begin
            cap_val_a.push_back(if_a.resultadoRetenido);
            cap_edge_a.push_back(n_edge);
            $display("[edge %0d] a capture sel=%0d res=%02h", n_edge, if_a.selectorOperacion, if_a.resultadoRetenido);
        end
        if (if_b.valido) begin
            cap_edge_b.push_back(n_edge);
            $display("[edge %0d] b capture sel=%0d res=%02h", n_edge, if_b.selectorOperacion, if_b.resultadoRetenido);
        end
        if (if_a.fin) begin
            fin_a++;
            chk("a.ocupado_with_fin", 32'(if_a.ocupado), 32'd0);
            $display("[edge %0d] a fin", n_edge);
        end
        if (if_b.fin) begin
            fin_edge_b = n_edge;
            $display("[edge %0d] b fin", n_edge);
        end
        cyc++;
        tick_a = tick_rand ? ($urandom_range(0, 2) == 0) : (cyc % 5 == 0);
    endtask

    task automatic wait_fin_a(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            step();
            seen = (if_a.fin == 1'b1);
        end
        chk("a.fin_wait", 32'(seen), 32'd1);
    endtask

    initial begin
        int  k_start;
        int  fin_before;
        bit  found;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_dwell[i] = 1'b0; m_latch_at[i] = -10; m_cap_at[i] = -10;
            m_fin_at[i] = -10; m_ticks[i] = 0; m_op[i] = 0; m_sel[i] = '0; m_num[i] = '0;
            m_res[i] = '0; m_val[i] = 1'b0; m_fin[i] = 1'b0; m_ocu[i] = 1'b0;
        end
        rst = 1'b1; auto = 1'b0; ini = 1'b0; selm = 2'd0; numb = 4'd0;
        tick_a = 1'b0; tick_rand = 1'b0;
        repeat (3) step();
        chk("rst.a.sel", 32'(if_a.selectorOperacion), 32'd0);
        chk("rst.a.res", 32'(if_a.resultadoRetenido), 32'd0);
        chk("rst.a.ocupado", 32'(if_a.ocupado), 32'd0);
        rst = 1'b0;

        // Manual pass-through
        selm = 2'd2; numb = 4'hA;
        step();
        chk("man.sel", 32'(if_a.selectorOperacion), 32'd2);
        chk("man.num", 32'(if_a.numRetenido), 32'hA);
        step();
        chk("man.res", 32'(if_a.resultadoRetenido), 32'hA2);
        chk("man.ocupado", 32'(if_a.ocupado), 32'd0);

        // Clean automatic run
        cap_val_a.delete(); cap_edge_a.delete(); cap_edge_b.delete();
        fin_before = fin_a;
        auto = 1'b1; numb = 4'h5; ini = 1'b1;
        k_start = n_edge + 1;
        step();
        ini = 1'b0;
        wait_fin_a(300);
        chk("run1.a.captures", 32'(cap_val_a.size()), 32'd4);
        for (int j = 0; j < 4 && j < cap_val_a.size(); j++)
            chk("run1.a.res", 32'(cap_val_a[j]), 32'({4'h5, 4'(j)}));
        if (cap_edge_a.size() > 0) chk("run1.a.first_cap_edge", 32'(cap_edge_a[0]), 32'(k_start + 3));
        chk("run1.a.fin_count", 32'(fin_a - fin_before), 32'd1);
        chk("run1.b.captures", 32'(cap_edge_b.size()), 32'd4);
        for (int j = 1; j < 4 && j < cap_edge_b.size(); j++)
            chk("run1.b.cap_spacing", 32'(cap_edge_b[j] - cap_edge_b[j-1]), 32'd3);
        if (cap_edge_b.size() == 4) chk("run1.b.fin_edge", 32'(fin_edge_b), 32'(cap_edge_b[3] + 2));

        // Operand change and start request mid-sequence are ignored
        repeat (3) step();
        cap_val_a.delete();
        fin_before = fin_a;
        numb = 4'h5; ini = 1'b1;
        step();
        ini = 1'b0;
        repeat (20) step();
        numb = 4'hF; ini = 1'b1;
        step();
        ini = 1'b0;
        wait_fin_a(300);
        repeat (10) step();
        chk("run2.a.captures", 32'(cap_val_a.size()), 32'd4);
        for (int j = 0; j < 4 && j < cap_val_a.size(); j++)
            chk("run2.a.res", 32'(cap_val_a[j]), 32'({4'h5, 4'(j)}));
        chk("run2.a.fin_count", 32'(fin_a - fin_before), 32'd1);
        chk("run2.a.ocupado_after", 32'(if_a.ocupado), 32'd0);

        // Abort from MOSTRAR with selector 1
        numb = 4'h3; ini = 1'b1;
        step();
        ini = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            found = m_act[0] && m_dwell[0] && (m_sel[0] == 2'd1);
        end
        chk("abort.reach_mostrar_sel1", 32'(found), 32'd1);
        fin_before = fin_a;
        auto = 1'b0; selm = 2'd3; numb = 4'h6;
        step();
        chk("abort.ocupado", 32'(if_a.ocupado), 32'd0);
        step();
        chk("abort.sel", 32'(if_a.selectorOperacion), 32'd3);
        chk("abort.num", 32'(if_a.numRetenido), 32'h6);
        step();
        chk("abort.res", 32'(if_a.resultadoRetenido), 32'h63);
        repeat (5) step();
        chk("abort.no_fin", 32'(fin_a - fin_before), 32'd0);

        // Reset during ESPERA of operation 2, then a full fresh run
        auto = 1'b1; numb = 4'h7; ini = 1'b1;
        step();
        ini = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            found = m_act[0] && (m_op[0] == 2) && (m_cap_at[0] == n_edge + 2);
        end
        chk("rst2.reach_espera_op2", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        chk("rst2.sel", 32'(if_a.selectorOperacion), 32'd0);
        chk("rst2.num", 32'(if_a.numRetenido), 32'd0);
        chk("rst2.res", 32'(if_a.resultadoRetenido), 32'd0);
        chk("rst2.ocupado", 32'(if_a.ocupado), 32'd0);
        chk("rst2.fin", 32'(if_a.fin), 32'd0);
        rst = 1'b0;
        cap_val_a.delete();
        numb = 4'h9; ini = 1'b1;
        step();
        ini = 1'b0;
        wait_fin_a(300);
        chk("rst2.rerun_captures", 32'(cap_val_a.size()), 32'd4);
        if (cap_val_a.size() > 0) chk("rst2.rerun_first", 32'(cap_val_a[0]), 32'h90);

        // Randomised traffic, random tick
        tick_rand = 1'b1;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 39) == 0) auto = ~auto;
            ini  = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) numb = 4'($urandom);
            if ($urandom_range(0, 3) == 0) selm = 2'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
